// File: rtl/game_pkg.sv
// Shared board-game constants, state encoding and the move-limit helper.
package game_pkg;

  localparam int unsigned N_SIZE = 19;
  localparam int unsigned POS_W  = 5;
  localparam int unsigned LVL_W  = 3;
  localparam int unsigned NUM_W  = 5;

  localparam logic [POS_W-1:0] CURSOR_HOME = POS_W'(9);
  localparam logic [NUM_W-1:0] LIMIT_BASE  = NUM_W'(5);
  localparam logic [NUM_W-1:0] LIMIT_STEP  = NUM_W'(3);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    OVER = 2'b10
  } state_e;

  // Level 7 gives 26, so NUM_W bits never overflow.
  function automatic logic [NUM_W-1:0] move_limit(input logic [LVL_W-1:0] lvl);
    return LIMIT_BASE + LIMIT_STEP * NUM_W'(lvl);
  endfunction

endpackage

// File: rtl/cursor_wrap.sv
// One cursor axis: inc/dec by one cell with wrap-around; opposing pulses cancel.
module cursor_wrap
  import game_pkg::*;
#(
  parameter int unsigned N_CELLS = 19
) (
  input  logic [POS_W-1:0] pos,
  input  logic             en,
  input  logic             inc,
  input  logic             dec,
  output logic [POS_W-1:0] next_c
);

  localparam logic [POS_W-1:0] LAST = POS_W'(N_CELLS - 1);

  always_comb begin
    next_c = pos;
    if (en && inc && !dec) begin
      next_c = (pos == LAST) ? '0 : pos + POS_W'(1);
    end else if (en && dec && !inc) begin
      next_c = (pos == '0) ? LAST : pos - POS_W'(1);
    end
  end

endmodule

// File: rtl/board_ctrl.sv
// Game board controller: cursor, two-stage stone placement and IDLE/PLAY/OVER flow.
module board_ctrl #(
  parameter int unsigned N_SIZE = game_pkg::N_SIZE
) (
  input  logic                         clk,
  input  logic                         rst_sys,
  input  logic                         btn_up,
  input  logic                         btn_down,
  input  logic                         btn_left,
  input  logic                         btn_right,
  input  logic                         btn_place,
  input  logic                         btn_start,
  input  logic                         btn_restart,
  input  logic [game_pkg::LVL_W-1:0]   level_sw,
  output logic [N_SIZE*N_SIZE-1:0]     map,
  output logic [game_pkg::POS_W-1:0]   x_index,
  output logic [game_pkg::POS_W-1:0]   y_index,
  output logic [game_pkg::NUM_W-1:0]   num,
  output logic [game_pkg::LVL_W-1:0]   level,
  output logic [1:0]                   state,
  output logic                         place_ack,
  output logic                         place_nack
);

  import game_pkg::*;

  localparam int unsigned CELLS = N_SIZE * N_SIZE;
  localparam int unsigned IDX_W = $clog2(CELLS);

  state_e             state_q, state_d;
  logic [CELLS-1:0]   map_d;
  logic [POS_W-1:0]   x_d, y_d, x_next_c, y_next_c;
  logic [NUM_W-1:0]   num_d, limit_c;
  logic [LVL_W-1:0]   level_d;
  logic               ack_d, nack_d;
  logic               pend_q, pend_d;
  logic               pocc_q, pocc_d;
  logic [IDX_W-1:0]   pidx_q, pidx_d, cur_idx_c;

  assign state     = state_q;
  assign limit_c   = move_limit(level);
  assign cur_idx_c = IDX_W'(y_index) * IDX_W'(N_SIZE) + IDX_W'(x_index);

  cursor_wrap #(.N_CELLS(N_SIZE)) u_x_axis (
    .pos    (x_index),
    .en     (state_q == PLAY),
    .inc    (btn_right),
    .dec    (btn_left),
    .next_c (x_next_c)
  );

  cursor_wrap #(.N_CELLS(N_SIZE)) u_y_axis (
    .pos    (y_index),
    .en     (state_q == PLAY),
    .inc    (btn_down),
    .dec    (btn_up),
    .next_c (y_next_c)
  );

  always_ff @(posedge clk) begin
    if (rst_sys) begin
      state_q    <= IDLE;
      map        <= '0;
      num        <= '0;
      level      <= '0;
      x_index    <= CURSOR_HOME;
      y_index    <= CURSOR_HOME;
      place_ack  <= 1'b0;
      place_nack <= 1'b0;
      pend_q     <= 1'b0;
      pocc_q     <= 1'b0;
      pidx_q     <= '0;
    end else begin
      state_q    <= state_d;
      map        <= map_d;
      num        <= num_d;
      level      <= level_d;
      x_index    <= x_d;
      y_index    <= y_d;
      place_ack  <= ack_d;
      place_nack <= nack_d;
      pend_q     <= pend_d;
      pocc_q     <= pocc_d;
      pidx_q     <= pidx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    map_d   = map;
    num_d   = num;
    level_d = level;
    x_d     = x_index;
    y_d     = y_index;
    ack_d   = 1'b0;
    nack_d  = 1'b0;
    pend_d  = pend_q;
    pocc_d  = pocc_q;
    pidx_d  = pidx_q;

    if (btn_restart) begin
      state_d = IDLE;
      map_d   = '0;
      num_d   = '0;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (btn_start) begin
            state_d = PLAY;
            level_d = level_sw;
            map_d   = '0;
            num_d   = '0;
            x_d     = CURSOR_HOME;
            y_d     = CURSOR_HOME;
            pend_d  = 1'b0;
          end
        end
        PLAY: begin
          x_d = x_next_c;
          y_d = y_next_c;
          // Stage 1 resolves the capture taken on the previous cycle.
          if (pend_q) begin
            pend_d = 1'b0;
            if (pocc_q) begin
              nack_d = 1'b1;
            end else begin
              map_d[pidx_q] = 1'b1;
              num_d         = num + NUM_W'(1);
              ack_d         = 1'b1;
            end
          end else if (btn_place && (num < limit_c)) begin
            pend_d = 1'b1;
            pidx_d = cur_idx_c;
            pocc_d = map[cur_idx_c];
          end
          if (num >= limit_c) begin
            state_d = OVER;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_ctrl.sv
// Directed bench for board_ctrl with a cell-array reference model checked every cycle.
module tb_board_ctrl;

  localparam int N = 19;

  localparam bit [6:0] B_UP = 7'h01;
  localparam bit [6:0] B_DN = 7'h02;
  localparam bit [6:0] B_LF = 7'h04;
  localparam bit [6:0] B_RT = 7'h08;
  localparam bit [6:0] B_PL = 7'h10;
  localparam bit [6:0] B_ST = 7'h20;
  localparam bit [6:0] B_RS = 7'h40;

  logic             clk = 1'b0;
  logic             rst_sys;
  logic             btn_up, btn_down, btn_left, btn_right;
  logic             btn_place, btn_start, btn_restart;
  logic [2:0]       level_sw;
  logic [N*N-1:0]   map;
  logic [4:0]       x_index, y_index, num;
  logic [2:0]       level;
  logic [1:0]       state;
  logic             place_ack, place_nack;

  always #5 clk = ~clk;

  board_ctrl #(.N_SIZE(N)) dut (
    .clk         (clk),
    .rst_sys     (rst_sys),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_place   (btn_place),
    .btn_start   (btn_start),
    .btn_restart (btn_restart),
    .level_sw    (level_sw),
    .map         (map),
    .x_index     (x_index),
    .y_index     (y_index),
    .num         (num),
    .level       (level),
    .state       (state),
    .place_ack   (place_ack),
    .place_nack  (place_nack)
  );

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  // Reference model: board as a 2-D cell array, cursor as plain integers.
  bit m_occ [N][N];
  int m_x, m_y, m_num, m_level, m_state;
  bit m_ack, m_nack, m_pend, m_over_next;
  int m_px, m_py;

  function automatic int lim(input int l);
    return 5 + 3 * l;
  endfunction

  task automatic clear_board();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        m_occ[i][j] = 1'b0;
  endtask

  always @(posedge clk) begin : model
    bit going_over;
    int dx, dy;
    m_ack  = 1'b0;
    m_nack = 1'b0;
    if (rst_sys) begin
      clear_board();
      m_num = 0; m_level = 0; m_state = 0; m_x = 9; m_y = 9;
      m_pend = 1'b0; m_over_next = 1'b0;
    end else if (btn_restart) begin
      clear_board();
      m_num = 0; m_state = 0; m_pend = 1'b0; m_over_next = 1'b0;
    end else if (m_state == 0) begin
      if (btn_start) begin
        clear_board();
        m_level = int'(level_sw); m_num = 0; m_x = 9; m_y = 9;
        m_state = 1; m_pend = 1'b0; m_over_next = 1'b0;
      end
    end else if (m_state == 1) begin
      going_over = m_over_next;
      if (m_pend) begin
        m_pend = 1'b0;
        if (m_occ[m_px][m_py]) begin
          m_nack = 1'b1;
        end else begin
          m_occ[m_px][m_py] = 1'b1;
          m_num++;
          m_ack = 1'b1;
          if (m_num == lim(m_level)) m_over_next = 1'b1;
        end
      end else if (btn_place && !going_over) begin
        m_pend = 1'b1; m_px = m_x; m_py = m_y;
      end
      dx = int'(btn_right) - int'(btn_left);
      dy = int'(btn_down) - int'(btn_up);
      m_x = (m_x + dx + N) % N;
      m_y = (m_y + dy + N) % N;
      if (going_over) begin
        m_state = 2; m_over_next = 1'b0;
      end
    end
  end

  task automatic cmp(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    logic [N*N-1:0] exp_map;
    if (check_en) begin
      for (int y = 0; y < N; y++)
        for (int x = 0; x < N; x++)
          exp_map[y*N+x] = m_occ[x][y];
      n_vec++;
      if (map !== exp_map) begin
        n_err++;
        $display("FAIL map: got %h expected %h at %0t", map, exp_map, $time);
      end
      cmp("state", int'(state), m_state);
      cmp("level", int'(level), m_level);
      cmp("num", int'(num), m_num);
      cmp("x_index", int'(x_index), m_x);
      cmp("y_index", int'(y_index), m_y);
      cmp("place_ack", int'(place_ack), int'(m_ack));
      cmp("place_nack", int'(place_nack), int'(m_nack));
    end
  end

  // Drive one cycle of button pulses; called just after a falling edge.
  task automatic cyc(input bit [6:0] b, input logic [2:0] sw);
    {btn_restart, btn_start, btn_place, btn_right, btn_left, btn_down, btn_up} = b;
    level_sw = sw;
    @(negedge clk);
    {btn_restart, btn_start, btn_place, btn_right, btn_left, btn_down, btn_up} = '0;
  endtask

  task automatic goto_cell(input int tx, input int ty);
    for (int i = 0; i < N && m_x != tx; i++) cyc(B_RT, 3'd0);
    for (int i = 0; i < N && m_y != ty; i++) cyc(B_DN, 3'd0);
  endtask

  initial begin
    rst_sys = 1'b1;
    {btn_restart, btn_start, btn_place, btn_right, btn_left, btn_down, btn_up} = '0;
    level_sw = 3'd0;
    @(negedge clk);
    @(negedge clk);
    check_en = 1'b1;
    cmp("rst_state", int'(state), 0);
    cmp("rst_x", int'(x_index), 9);
    cmp("rst_y", int'(y_index), 9);
    cmp("rst_map_zero", int'(map == '0), 1);
    rst_sys = 1'b0;

    // Moves in IDLE are ignored; start latches level 2.
    cyc(B_RT, 3'd0);
    cyc(B_ST, 3'd2);
    cmp("start_state", int'(state), 1);
    cmp("start_level", int'(level), 2);
    cmp("start_x", int'(x_index), 9);
    cmp("start_y", int'(y_index), 9);
    cmp("start_num", int'(num), 0);

    for (int i = 0; i < 9; i++) cyc(B_RT, 3'd0);
    for (int i = 0; i < 9; i++) cyc(B_UP, 3'd0);
    cmp("corner_x", int'(x_index), 18);
    cmp("corner_y", int'(y_index), 0);
    cyc(B_RT | B_UP, 3'd0);
    cmp("wrap_x", int'(x_index), 0);
    cmp("wrap_y", int'(y_index), 18);
    cyc(B_LF | B_RT, 3'd0);
    cmp("cancel_x", int'(x_index), 0);
    cyc(B_UP | B_DN | B_LF, 3'd0);
    cmp("cancel_y", int'(y_index), 18);
    cyc(B_ST, 3'd5);
    cmp("start_in_play", int'(level), 2);

    goto_cell(3, 4);
    cyc(B_PL, 3'd0);
    cmp("pend_no_ack", int'(place_ack), 0);
    cyc(0, 3'd0);
    cmp("ack_34", int'(place_ack), 1);
    cmp("map79", int'(map[79]), 1);
    cmp("num_after_ack", int'(num), 1);
    cyc(B_PL, 3'd0);
    cyc(0, 3'd0);
    cmp("nack_34", int'(place_nack), 1);
    cmp("num_after_nack", int'(num), 1);

    goto_cell(5, 5);
    cyc(B_PL | B_RT, 3'd0);
    cyc(0, 3'd0);
    cmp("map100", int'(map[100]), 1);
    cmp("move_place_x", int'(x_index), 6);
    cmp("move_place_y", int'(y_index), 5);

    // Second place while pending is dropped.
    cyc(B_PL, 3'd0);
    cyc(B_PL, 3'd0);
    cyc(0, 3'd0);
    cyc(0, 3'd0);
    cmp("pend_ignore_num", int'(num), 3);

    cyc(B_PL, 3'd0);
    cyc(B_RS, 3'd0);
    cmp("rs_ack", int'(place_ack), 0);
    cmp("rs_nack", int'(place_nack), 0);
    cmp("rs_state", int'(state), 0);
    cmp("rs_map_zero", int'(map == '0), 1);
    cyc(0, 3'd0);
    cyc(0, 3'd0);

    // Level 0: five placements end the game.
    cyc(B_ST, 3'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(B_PL, 3'd0);
      cyc(0, 3'd0);
      cyc(B_RT, 3'd0);
    end
    cyc(B_PL, 3'd0);
    cyc(0, 3'd0);
    cmp("fifth_ack", int'(place_ack), 1);
    cmp("fifth_num", int'(num), 5);
    cmp("fifth_still_play", int'(state), 1);
    cyc(0, 3'd0);
    cmp("over_state", int'(state), 2);
    cyc(B_PL, 3'd0);
    cyc(0, 3'd0);
    cyc(0, 3'd0);
    cmp("over_num", int'(num), 5);
    cyc(B_ST, 3'd3);
    cmp("start_in_over", int'(state), 2);

    cyc(B_RS, 3'd0);
    cyc(B_ST, 3'd7);
    cmp("level7", int'(level), 7);
    cyc(B_PL, 3'd0);
    rst_sys = 1'b1;
    cyc(0, 3'd0);
    rst_sys = 1'b0;
    cmp("mid_rst_state", int'(state), 0);
    cmp("mid_rst_level", int'(level), 0);
    cmp("mid_rst_num", int'(num), 0);
    cmp("mid_rst_map_zero", int'(map == '0), 1);
    cyc(0, 3'd0);
    cmp("mid_rst_ack", int'(place_ack), 0);
    cmp("mid_rst_nack", int'(place_nack), 0);
    cyc(0, 3'd0);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/board_ctrl.md
BOARD_CTRL -- requirements
Module: board_ctrl

Interface
REQ-001 The module SHALL have parameter N_SIZE, default 19, meaning the board edge length in cells; the map width is N_SIZE*N_SIZE.
REQ-002 The module SHALL have the port clk, input, 1 bit: the system clock; all logic is on its rising edge.
REQ-003 The module SHALL have the port rst_sys, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have the ports btn_up, btn_down, btn_left, btn_right, input, 1 bit each: single-cycle debounced move pulses.
REQ-005 The module SHALL have the ports btn_place, btn_start, btn_restart, input, 1 bit each: single-cycle command pulses.
REQ-006 The module SHALL have the port level_sw, input, 3 bits: the difficulty level, sampled only on start.
REQ-007 The module SHALL have the port map, output, 361 bits: the occupancy map; bit index = y*19+x; 1 = stone present.
REQ-008 The module SHALL have the ports x_index and y_index, output, 5 bits each: the cursor column and row, range 0..18.
REQ-009 The module SHALL have the port num, output, 5 bits: the count of accepted placements.
REQ-010 The module SHALL have the port level, output, 3 bits: the latched level.
REQ-011 The module SHALL have the port state, output, 2 bits: the game state, encoded IDLE=00, PLAY=01, OVER=10; 11 is unused.
REQ-012 The module SHALL have the ports place_ack and place_nack, output, 1 bit each: single-cycle placement result pulses.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 State transitions: IDLE->PLAY on btn_start; PLAY->OVER when num reaches limit; any state->IDLE on btn_restart.
REQ-015 The move limit SHALL be 5 + 3*level (level 0..7 gives 5..26), computed at 5-bit width without overflow.
REQ-016 On the IDLE->PLAY transition, the block SHALL latch level_sw into level, clear map and num, and set the cursor to (9,9).
REQ-017 The cursor SHALL move only in PLAY, by one cell per pulse.
REQ-018 Cursor wrap-around: right from x=18 gives 0; left from 0 gives 18; likewise for y with down/up. up=y-1.
REQ-019 If btn_up and btn_down arrive in the same cycle, y SHALL be unchanged; the same rule applies to btn_left and btn_right for x. Horizontal and vertical moves in the same cycle SHALL both apply.
REQ-020 btn_place in PLAY SHALL be handled in a two-stage handshake:
- Cycle 0: capture the cursor and read the map bit.
- Cycle 1, if the cell is empty: set the bit, increment num, and pulse place_ack.
- Cycle 1, if the cell is occupied: pulse place_nack; map and num are unchanged.
REQ-021 btn_place and a move pulse in the same cycle: the placement SHALL use the pre-move cursor, and the move SHALL still apply.
REQ-022 btn_place arriving while a placement is pending (cycle 1) SHALL be ignored; no ack or nack is produced for it.
REQ-023 btn_place outside PLAY SHALL be ignored, with no ack or nack.
REQ-024 When an ack raises num to the limit, state SHALL read OVER in the cycle after the ack pulse.
REQ-025 num SHALL never exceed the limit; OVER blocks further placements.
REQ-026 btn_restart SHALL have priority over every other input in the same cycle; a pending placement is discarded (no ack or nack) and map is cleared.
REQ-027 btn_start outside IDLE SHALL be ignored.

Reset
REQ-028 While rst_sys=1 at a clock edge, the outputs SHALL take these values:
- map = 0, num = 0, level = 0, state = IDLE
- x_index = 9, y_index = 9
- place_ack = 0, place_nack = 0, and the pending flag is cleared.
REQ-029 Reset SHALL take effect mid-placement with the same result as REQ-028; no pulse is emitted afterwards.

Structure
REQ-030 A shared package (game_pkg) SHALL hold:
- N_SIZE
- the state encodings IDLE/PLAY/OVER
- the cursor home value 9
- the limit base 5 and step 3.
REQ-031 One sub-module, cursor_wrap, SHALL implement the per-axis inc/dec with wrap and cancel; it is instantiated twice (x and y).
REQ-032 The map SHALL be a flat 361-bit register with single-bit write enable; no RAM inference is required.

Verification
REQ-033 Reset, then btn_start with level_sw=2 -> state=01, level=2, cursor (9,9), num=0, map=0.
REQ-034 From (18,0), pulse btn_right and btn_up -> cursor (0,18); a simultaneous btn_left+btn_right -> x unchanged.
REQ-035 Place at (3,4) -> place_ack one cycle later, map[79]=1, num=1; place again at (3,4) -> place_nack, num stays 1.
REQ-036 With level=0, make 5 distinct placements -> state=10 after the 5th ack; a 6th btn_place -> no ack or nack, num=5.
REQ-037 btn_place followed next cycle by btn_restart -> no ack or nack, map=0, state=00; rst_sys mid-placement -> REQ-028 values.
REQ-038 btn_place together with btn_right at (5,5) -> map[100]=1, cursor (6,5).
